// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operand width,
// md_op codes and FSM states.
package hilo_pkg;

    localparam int WIDTH     = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_e;

    // Only MUL and DIV launch work; NONE and the reserved code are no-ops.
    function automatic logic md_op_valid(input logic [1:0] op);
        return (op == MD_MUL) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/hilo_unit_div_iter.sv
// Iterative restoring divider: magnitude conversion on load, one quotient bit
// per run cycle, sign fix applied combinationally on the final step.
module div_iter #(
    parameter int WIDTH     = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int              CW   = $clog2(DIV_STEPS);
    localparam logic [CW-1:0]   LAST = CW'(DIV_STEPS - 1);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1'b1);
    endfunction

    // Two's complement of -2^(WIDTH-1) is itself, which is the correct magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            return negate(v);
        end else begin
            return v;
        end
    endfunction

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] a_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             zero_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    // Divider datapath and step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            div_r   <= {WIDTH{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            zero_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (load) begin
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= magnitude(a, is_signed);
            div_r   <= magnitude(b, is_signed);
            a_r     <= a;
            neg_q_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r <= is_signed & a[WIDTH-1];
            zero_r  <= (b == {WIDTH{1'b0}});
            cnt_r   <= {CW{1'b0}};
        end else if (run) begin
            rem_r   <= rem_step_s;
            quo_r   <= quo_step_s;
            cnt_r   <= cnt_r + CW'(1'b1);
        end
    end

    // One shift-subtract step; quo_r shifts dividend bits out and quotient bits in.
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        ge_s       = (shifted_s >= {1'b0, div_r});
        rem_step_s = ge_s ? (shifted_s[WIDTH-1:0] - div_r) : shifted_s[WIDTH-1:0];
        quo_step_s = {quo_r[WIDTH-2:0], ge_s};
    end

    assign done = run & (cnt_r == LAST);

    // Divide-by-zero returns all-ones / raw dividend with no sign fix.
    always_comb begin
        if (zero_r) begin
            quo = {WIDTH{1'b1}};
            rem = a_r;
        end else begin
            quo = neg_q_r ? negate(quo_step_s) : quo_step_s;
            rem = neg_r_r ? negate(rem_step_s) : rem_step_s;
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers with a 2-cycle multiplier, an iterative
// divider and a pipeline stall while an operation is in flight.
module hilo_unit #(
    parameter int WIDTH     = hilo_pkg::WIDTH,
    parameter int DIV_STEPS = hilo_pkg::DIV_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             md_signed,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             flush,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    import hilo_pkg::*;

    localparam int PW = 2 * WIDTH;

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             signed_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             start_ok_s;
    logic             div_load_s;
    logic             div_run_s;
    logic             div_done_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [PW-1:0]    ext_a_s;
    logic [PW-1:0]    ext_b_s;
    logic [PW-1:0]    product_s;
    logic             res_we_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    assign start_ok_s = (state_r == ST_IDLE) & md_start & ~flush & md_op_valid(md_op);
    assign div_run_s  = (state_r == ST_DIV) & ~flush;

    assign ext_a_s   = {{WIDTH{signed_r & a_r[WIDTH-1]}}, a_r};
    assign ext_b_s   = {{WIDTH{signed_r & b_r[WIDTH-1]}}, b_r};
    assign product_s = ext_a_s * ext_b_s;

    div_iter #(
        .WIDTH     (WIDTH),
        .DIV_STEPS (DIV_STEPS)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load_s),
        .run       (div_run_s),
        .is_signed (md_signed),
        .a         (md_a),
        .b         (md_b),
        .done      (div_done_s),
        .quo       (div_quo_s),
        .rem       (div_rem_s)
    );

    // Next-state and result-write decode; flush always beats completion.
    always_comb begin
        state_next_s = state_r;
        div_load_s   = 1'b0;
        res_we_s     = 1'b0;
        res_hi_s     = product_s[PW-1:WIDTH];
        res_lo_s     = product_s[WIDTH-1:0];
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (md_op == MD_MUL) begin
                        state_next_s = ST_MUL;
                    end else begin
                        state_next_s = ST_DIV;
                        div_load_s   = 1'b1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                state_next_s = ST_IDLE;
                if (flush) begin
                    res_we_s = 1'b0;
                end else begin
                    res_we_s = 1'b1;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (div_done_s) begin
                    state_next_s = ST_IDLE;
                    res_we_s     = 1'b1;
                    res_hi_s     = div_rem_s;
                    res_lo_s     = div_quo_s;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Multiplier operands captured when an operation is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            signed_r <= 1'b0;
        end else if (start_ok_s) begin
            a_r      <= md_a;
            b_r      <= md_b;
            signed_r <= md_signed;
        end
    end

    // HI/LO registers; a unit result overrides direct writes on both halves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (res_we_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else begin
            if (hilo_we[1]) begin
                hi_r <= hilo_wdata;
            end
            if (hilo_we[0]) begin
                lo_r <= hilo_wdata;
            end
        end
    end

    assign hi_o    = hi_r;
    assign lo_o    = lo_r;
    assign busy_o  = (state_r != ST_IDLE);
    assign stall_o = ((state_r == ST_IDLE) & md_start & md_op_valid(md_op)) | busy_o;

endmodule
